// File: rtl/rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32_mem_arbiter
//
// Shares one single-port, fixed-latency memory between the RV32 instruction
// fetch port (IF) and the load/store port (LS). At most one request is
// granted per cycle. The winning command is registered onto the memory bus,
// and a tag pipeline routes the returning read data back to its issuer.
// Writes complete silently.
//
// Build option:
//   RV32_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration on contention
//                            undefined -> fixed priority, LS always wins
//
// Parameters:
//   ADDR_W  address width of all ports
//   DATA_W  data width of all ports
//   RD_LAT  memory read latency in cycles (1..4)
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-low reset
//   if_req_i/if_addr_i    fetch read request and address
//   if_gnt_o              fetch accepted this cycle (combinational)
//   if_rvalid_o/if_rdata_o fetch read data return
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i  load/store request
//   ls_gnt_o              load/store accepted this cycle (combinational)
//   ls_rvalid_o/ls_rdata_o load data return
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  registered memory command
//   mem_rdata_i           memory read data, RD_LAT cycles after a read command
// ---------------------------------------------------------------------------
module rv32_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic              if_gnt_s;
  logic              ls_gnt_s;
  // Owner of the command currently on the memory bus: 1 = LS, 0 = IF.
  logic              mem_own_r;
  logic              stage0_vld_s;
  logic [RD_LAT-1:0] tag_vld_r;
  logic [RD_LAT-1:0] tag_own_r;
  logic [RD_LAT-1:0] tag_vld_nxt_s;
  logic [RD_LAT-1:0] tag_own_nxt_s;

`ifdef RV32_ARB_ROUND_ROBIN_EN
  // 0 = IF wins the next contention, 1 = LS wins the next contention.
  logic rr_ptr_r;
`endif

  // Grant decode: depends only on the two requests and the priority state.
  always_comb begin
    if_gnt_s = 1'b0;
    ls_gnt_s = 1'b0;
    if (if_req_i && ls_req_i) begin
`ifdef RV32_ARB_ROUND_ROBIN_EN
      if (rr_ptr_r) begin
        ls_gnt_s = 1'b1;
      end else begin
        if_gnt_s = 1'b1;
      end
`else
      ls_gnt_s = 1'b1;
`endif
    end else if (if_req_i) begin
      if_gnt_s = 1'b1;
    end else if (ls_req_i) begin
      ls_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end
  end

  assign if_gnt_o = if_gnt_s;
  assign ls_gnt_o = ls_gnt_s;

`ifdef RV32_ARB_ROUND_ROBIN_EN
  // Round-robin pointer: after every acceptance it points away from the winner.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_ptr_r <= 1'b0;
    end else if (if_gnt_s) begin
      rr_ptr_r <= 1'b1;
    end else if (ls_gnt_s) begin
      rr_ptr_r <= 1'b0;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // Command register: load the winner's command, otherwise drop req and hold the rest.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= {ADDR_W{1'b0}};
      mem_wdata_o <= {DATA_W{1'b0}};
      mem_own_r   <= 1'b0;
    end else if (if_gnt_s) begin
      // Fetches never write, so the write data bus keeps its last value.
      mem_req_o   <= 1'b1;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= if_addr_i;
      mem_own_r   <= 1'b0;
    end else if (ls_gnt_s) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= ls_we_i;
      mem_addr_o  <= ls_addr_i;
      mem_wdata_o <= ls_wdata_i;
      mem_own_r   <= 1'b1;
    end else begin
      mem_req_o   <= 1'b0;
    end
  end

  // The tag enters the pipeline alongside the registered read command, so the
  // last stage lines up with the cycle the memory returns data.
  assign stage0_vld_s = mem_req_o & ~mem_we_o;

  if (RD_LAT == 1) begin : g_tag_single
    assign tag_vld_nxt_s = stage0_vld_s;
    assign tag_own_nxt_s = mem_own_r;
  end else begin : g_tag_multi
    assign tag_vld_nxt_s = {tag_vld_r[RD_LAT-2:0], stage0_vld_s};
    assign tag_own_nxt_s = {tag_own_r[RD_LAT-2:0], mem_own_r};
  end

  // Tag pipeline: shifts every cycle; reset discards all in-flight reads.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tag_vld_r <= {RD_LAT{1'b0}};
      tag_own_r <= {RD_LAT{1'b0}};
    end else begin
      tag_vld_r <= tag_vld_nxt_s;
      tag_own_r <= tag_own_nxt_s;
    end
  end

  // Return path: the last tag stage picks the destination; data is broadcast.
  assign if_rvalid_o = tag_vld_r[RD_LAT-1] & ~tag_own_r[RD_LAT-1];
  assign ls_rvalid_o = tag_vld_r[RD_LAT-1] &  tag_own_r[RD_LAT-1];
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32_mem_arbiter
//
// Drives four arbiter instances (RD_LAT = 1..4) with identical request
// streams. A word-addressed memory model answers each instance's bus, and a
// request-level reference (grant policy, accepted-request log with expected
// return cycle, reference memory) predicts grants, bus commands and returns.
// ---------------------------------------------------------------------------
module tb_rv32_mem_arbiter;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = 32'h0;
  logic [31:0] ls_wdata = 32'h0;

  logic [NI-1:0] if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we;
  logic [31:0]   if_rdata [NI];
  logic [31:0]   ls_rdata [NI];
  logic [31:0]   mem_addr [NI];
  logic [31:0]   mem_wdata[NI];
  logic [31:0]   mem_rdata[NI];

  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(g + 1)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_gnt_o    (if_gnt[g]),
      .if_rvalid_o (if_rvalid[g]),
      .if_rdata_o  (if_rdata[g]),
      .ls_req_i    (ls_req),
      .ls_we_i     (ls_we),
      .ls_addr_i   (ls_addr),
      .ls_wdata_i  (ls_wdata),
      .ls_gnt_o    (ls_gnt[g]),
      .ls_rvalid_o (ls_rvalid[g]),
      .ls_rdata_o  (ls_rdata[g]),
      .mem_req_o   (mem_req[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (mem_rdata[g])
    );
  end

  // Reference state
  typedef struct {
    int          acc;   // cycle in which the read was accepted
    bit          own;   // 0 = IF, 1 = LS
    logic [31:0] data;
  } rec_t;

  rec_t        rec[$];
  int          head[NI];
  logic [31:0] ref_mem[64];
  bit          last_ls;          // most recent winner was LS
  logic        x_req, x_we;
  logic [31:0] x_addr, x_wdata;

  // Memory model state, one per instance
  logic [31:0] bus_mem[NI][64];
  logic [31:0] rdq[NI][8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    x_req = 1'b0; x_we = 1'b0; x_addr = 32'h0; x_wdata = 32'h0;
    last_ls = 1'b1;
    for (int k = 0; k < NI; k++) head[k] = rec.size();
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_mem_req_L%0d", tag, k + 1), 32'(mem_req[k]), 32'h0);
      chk($sformatf("%s_mem_we_L%0d", tag, k + 1), 32'(mem_we[k]), 32'h0);
      chk($sformatf("%s_mem_addr_L%0d", tag, k + 1), mem_addr[k], 32'h0);
      chk($sformatf("%s_mem_wdata_L%0d", tag, k + 1), mem_wdata[k], 32'h0);
      chk($sformatf("%s_if_rvalid_L%0d", tag, k + 1), 32'(if_rvalid[k]), 32'h0);
      chk($sformatf("%s_ls_rvalid_L%0d", tag, k + 1), 32'(ls_rvalid[k]), 32'h0);
    end
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic run_cycle(input logic ir, input logic [31:0] ia, input logic lr,
                           input logic lw, input logic [31:0] la, input logic [31:0] lwd);
    int  win;  // 0 none, 1 IF, 2 LS
    bit  ev_if, ev_ls;
    logic [31:0] ed;
    // Bus side: check the registered command, then let memory act on it.
    for (int k = 0; k < NI; k++) begin
      int idx;
      chk($sformatf("mem_req_L%0d", k + 1), 32'(mem_req[k]), 32'(x_req));
      chk($sformatf("mem_we_L%0d", k + 1), 32'(mem_we[k]), 32'(x_we));
      chk($sformatf("mem_addr_L%0d", k + 1), mem_addr[k], x_addr);
      chk($sformatf("mem_wdata_L%0d", k + 1), mem_wdata[k], x_wdata);
      idx = int'(mem_addr[k] >> 2) & 63;
      if (mem_req[k] && mem_we[k]) bus_mem[k][idx] = mem_wdata[k];
      else if (mem_req[k]) rdq[k][(cyc + k + 1) & 7] = bus_mem[k][idx];
      mem_rdata[k] = rdq[k][cyc & 7];
      rdq[k][cyc & 7] = $urandom();
    end
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = lwd;
    #1;
    // Arbitration policy
    if (ir && lr) begin
`ifdef RV32_ARB_ROUND_ROBIN_EN
      win = last_ls ? 1 : 2;
`else
      win = 2;
`endif
    end else if (ir) win = 1;
    else if (lr) win = 2;
    else win = 0;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("if_gnt_L%0d", k + 1), 32'(if_gnt[k]), 32'(win == 1));
      chk($sformatf("ls_gnt_L%0d", k + 1), 32'(ls_gnt[k]), 32'(win == 2));
      ev_if = 1'b0; ev_ls = 1'b0; ed = 32'h0;
      if (head[k] < rec.size() && rec[head[k]].acc + k + 2 == cyc) begin
        ev_if = !rec[head[k]].own;
        ev_ls = rec[head[k]].own;
        ed = rec[head[k]].data;
        head[k]++;
      end
      chk($sformatf("if_rvalid_L%0d", k + 1), 32'(if_rvalid[k]), 32'(ev_if));
      chk($sformatf("ls_rvalid_L%0d", k + 1), 32'(ls_rvalid[k]), 32'(ev_ls));
      if (ev_if) chk($sformatf("if_rdata_L%0d", k + 1), if_rdata[k], ed);
      if (ev_ls) chk($sformatf("ls_rdata_L%0d", k + 1), ls_rdata[k], ed);
    end
    // Reference update on acceptance
    if (win == 1) begin
      rec.push_back('{acc: cyc, own: 1'b0, data: ref_mem[int'(ia >> 2) & 63]});
      x_req = 1'b1; x_we = 1'b0; x_addr = ia;
      last_ls = 1'b0;
    end else if (win == 2) begin
      if (lw) ref_mem[int'(la >> 2) & 63] = lwd;
      else rec.push_back('{acc: cyc, own: 1'b1, data: ref_mem[int'(la >> 2) & 63]});
      x_req = 1'b1; x_we = lw; x_addr = la; x_wdata = lwd;
      last_ls = 1'b1;
    end else begin
      x_req = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      run_cycle($urandom_range(0, 3) != 0, $urandom() & 32'h0000_00FC,
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom() & 32'h0000_00FC, $urandom());
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) begin
      ref_mem[a] = $urandom();
      for (int k = 0; k < NI; k++) bus_mem[k][a] = ref_mem[a];
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    for (int k = 0; k < NI; k++) begin
      bus_mem[k][4] = 32'hDEAD_BEEF;
      mem_rdata[k] = 32'h0;
      for (int s = 0; s < 8; s++) rdq[k][s] = 32'h0;
    end
    model_reset();

    // Power-on reset
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fetch from 0x10 returning 0xDEADBEEF, then idle for the return
    run_cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Store 0x5A5A5A5A to 0x20, then load it back on the next cycle
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h5A5A_5A5A);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Contention: both held for 6 cycles, then IF alone
    for (int i = 0; i < 6; i++)
      run_cycle(1'b1, 32'h40 + 32'(i * 4), 1'b1, 1'b0, 32'h80 + 32'(i * 4), 32'h0);
    run_cycle(1'b1, 32'h58, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Random mixed traffic
    rand_cycles(1500);

    // Two reads in flight, then an asynchronous reset mid-cycle
    run_cycle(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
    if_req = 1'b0;
    ls_req = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_rst_hold");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    rand_cycles(1500);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int k = 0; k < NI; k++)
      chk($sformatf("all_reads_returned_L%0d", k + 1), 32'(head[k]), 32'(rec.size()));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
